// File: rtl/numberle_pkg.sv
// Shared types and sizing for the Numberle guess controller.
// Digit 0 is always the leftmost (most significant) position.
package numberle_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned CODE_W     = NUM_DIGITS * DIGIT_W;
    localparam int unsigned STAT_W     = 2;
    localparam int unsigned STATUS_W   = NUM_DIGITS * STAT_W;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned MAX_KEY    = 9;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        SCORE_EXACT,
        SCORE_MISP,
        RESULT,
        SHOW,
        WIN,
        LOSE
    } state_t;

    typedef enum logic [STAT_W-1:0] {
        ST_NONE    = 2'b00,
        ST_ABSENT  = 2'b01,
        ST_MISP    = 2'b10,
        ST_CORRECT = 2'b11
    } status_t;

    typedef logic [DIGIT_W-1:0] digit_t;

    // Keypad codes A..F are not part of a guess.
    function automatic logic is_digit(input digit_t code);
        return code <= DIGIT_W'(MAX_KEY);
    endfunction

endpackage

// File: rtl/numberle_guess_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level.
// The edge is a combinational pulse while the level is high and its last sample was low.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise_c
);

    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise_c = level & ~level_q;

endmodule

// File: rtl/numberle_guess_ctrl.sv
// Numberle game sequencer: builds a 4-digit guess from keypad input, scores it
// against a latched secret over six cycles and tracks attempts and win/lose.
module numberle_guess_ctrl
    import numberle_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 6,
    parameter int unsigned TRY_W     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                new_game,
    input  logic [CODE_W-1:0]   secret,
    input  logic                key_valid,
    input  logic [DIGIT_W-1:0]  key_code,
    input  logic                del_btn,
    input  logic                sub_btn,
    output logic [CODE_W-1:0]   disp_digits,
    output logic [NUM_DIGITS-1:0] disp_blank,
    output logic [STATUS_W-1:0] digit_status,
    output logic [TRY_W-1:0]    attempt,
    output logic                busy,
    output logic                win,
    output logic                lose
);

    state_t                state_q, state_d;
    digit_t                guess_q  [NUM_DIGITS];
    digit_t                guess_d  [NUM_DIGITS];
    digit_t                secret_q [NUM_DIGITS];
    digit_t                secret_d [NUM_DIGITS];
    status_t               status_q [NUM_DIGITS];
    status_t               status_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic [NUM_DIGITS-1:0] sec_used_q, sec_used_d;
    logic [NUM_DIGITS-1:0] g_done_q, g_done_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [TRY_W-1:0]      attempt_q, attempt_d;
    logic                  busy_q, win_q, lose_q;

    logic                  del_edge_c, sub_edge_c, key_ok_c;
    logic [IDX_W-1:0]      wr_pos, del_pos, match_j;
    logic                  found, all_correct;
    logic [TRY_W-1:0]      attempt_inc;

    btn_edge u_del_edge (
        .clk    (clk),
        .rst    (rst),
        .level  (del_btn),
        .rise_c (del_edge_c)
    );

    btn_edge u_sub_edge (
        .clk    (clk),
        .rst    (rst),
        .level  (sub_btn),
        .rise_c (sub_edge_c)
    );

    assign key_ok_c    = key_valid && is_digit(key_code);
    assign wr_pos      = count_q[IDX_W-1:0];
    assign del_pos     = IDX_W'(count_q - CNT_W'(1));
    assign attempt_inc = attempt_q + TRY_W'(1);

    // Lowest unused secret position holding the digit under test in the misplaced pass.
    always_comb begin
        found   = 1'b0;
        match_j = '0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (!found && !sec_used_q[j] && (secret_q[j] == guess_q[idx_q])) begin
                found   = 1'b1;
                match_j = IDX_W'(j);
            end
        end
    end

    always_comb begin
        all_correct = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (status_q[i] != ST_CORRECT) begin
                all_correct = 1'b0;
            end
        end
    end

    // Next-state and datapath update; new_game overrides everything else.
    always_comb begin
        state_d    = state_q;
        guess_d    = guess_q;
        secret_d   = secret_q;
        status_d   = status_q;
        blank_d    = blank_q;
        sec_used_d = sec_used_q;
        g_done_d   = g_done_q;
        count_d    = count_q;
        idx_d      = idx_q;
        attempt_d  = attempt_q;

        if (new_game) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                secret_d[i] = secret[DIGIT_W*(NUM_DIGITS-1-i) +: DIGIT_W];
                guess_d[i]  = '0;
                status_d[i] = ST_NONE;
            end
            blank_d    = '1;
            sec_used_d = '0;
            g_done_d   = '0;
            count_d    = '0;
            idx_d      = '0;
            attempt_d  = '0;
            state_d    = ENTRY;
        end else begin
            case (state_q)
                IDLE: begin
                end

                // Submit is judged on the pre-update count and swallows a same-cycle key/delete.
                ENTRY: begin
                    if (sub_edge_c && (count_q == CNT_W'(NUM_DIGITS))) begin
                        state_d = SCORE_EXACT;
                    end else if (del_edge_c) begin
                        if (count_q != '0) begin
                            count_d          = count_q - CNT_W'(1);
                            guess_d[del_pos] = '0;
                            blank_d[IDX_W'(NUM_DIGITS-1) - del_pos] = 1'b1;
                        end
                    end else if (key_ok_c && (count_q < CNT_W'(NUM_DIGITS))) begin
                        count_d         = count_q + CNT_W'(1);
                        guess_d[wr_pos] = key_code;
                        blank_d[IDX_W'(NUM_DIGITS-1) - wr_pos] = 1'b0;
                    end
                end

                SCORE_EXACT: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (guess_q[i] == secret_q[i]) begin
                            status_d[i]   = ST_CORRECT;
                            sec_used_d[i] = 1'b1;
                            g_done_d[i]   = 1'b1;
                        end else begin
                            status_d[i]   = ST_ABSENT;
                            sec_used_d[i] = 1'b0;
                            g_done_d[i]   = 1'b0;
                        end
                    end
                    idx_d   = '0;
                    state_d = SCORE_MISP;
                end

                SCORE_MISP: begin
                    if (!g_done_q[idx_q] && found) begin
                        status_d[idx_q]     = ST_MISP;
                        sec_used_d[match_j] = 1'b1;
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_DIGITS-1)) begin
                        state_d = RESULT;
                    end
                end

                RESULT: begin
                    attempt_d = attempt_inc;
                    if (all_correct) begin
                        state_d = WIN;
                    end else if (attempt_inc == TRY_W'(MAX_TRIES)) begin
                        state_d = LOSE;
                    end else begin
                        state_d = SHOW;
                    end
                end

                // First digit of the next guess replaces the scored one.
                SHOW: begin
                    if (key_ok_c) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            guess_d[i]  = '0;
                            status_d[i] = ST_NONE;
                        end
                        guess_d[0] = key_code;
                        count_d    = CNT_W'(1);
                        blank_d    = {1'b0, {(NUM_DIGITS-1){1'b1}}};
                        state_d    = ENTRY;
                    end
                end

                WIN, LOSE: begin
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                guess_q[i]  <= '0;
                secret_q[i] <= '0;
                status_q[i] <= ST_NONE;
            end
            blank_q    <= '1;
            sec_used_q <= '0;
            g_done_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            attempt_q  <= '0;
            busy_q     <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            guess_q    <= guess_d;
            secret_q   <= secret_d;
            status_q   <= status_d;
            blank_q    <= blank_d;
            sec_used_q <= sec_used_d;
            g_done_q   <= g_done_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            attempt_q  <= attempt_d;
            busy_q     <= (state_d == SCORE_EXACT) || (state_d == SCORE_MISP);
            win_q      <= (state_d == WIN);
            lose_q     <= (state_d == LOSE);
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_pack
        assign disp_digits[DIGIT_W*(NUM_DIGITS-1-i) +: DIGIT_W] = guess_q[i];
        assign digit_status[STAT_W*(NUM_DIGITS-1-i) +: STAT_W]  = status_q[i];
    end

    assign disp_blank = blank_q;
    assign attempt    = attempt_q;
    assign busy       = busy_q;
    assign win        = win_q;
    assign lose       = lose_q;

endmodule

// File: tb/tb_numberle_guess_ctrl.sv
// Self-checking bench for numberle_guess_ctrl: directed scenarios plus
// randomized games scored by a digit-histogram reference model.
module tb_numberle_guess_ctrl;

    localparam int unsigned MAX_TRIES = 6;
    localparam int unsigned TRY_W     = 3;

    logic        clk, rst, new_game;
    logic [15:0] secret;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        del_btn, sub_btn;
    logic [15:0] disp_digits;
    logic [3:0]  disp_blank;
    logic [7:0]  digit_status;
    logic [2:0]  attempt;
    logic        busy, win, lose;

    int n_vec = 0;
    int n_err = 0;

    numberle_guess_ctrl #(.MAX_TRIES(MAX_TRIES), .TRY_W(TRY_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .new_game     (new_game),
        .secret       (secret),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .del_btn      (del_btn),
        .sub_btn      (sub_btn),
        .disp_digits  (disp_digits),
        .disp_blank   (disp_blank),
        .digit_status (digit_status),
        .attempt      (attempt),
        .busy         (busy),
        .win          (win),
        .lose         (lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Wordle scoring: exact hits first, then misplaced hits limited by how many
    // unmatched copies of each value remain in the secret.
    function automatic logic [7:0] ref_score(input logic [15:0] s, input logic [15:0] g);
        int         left [16];
        logic [3:0] sd, gd;
        logic [1:0] st [4];
        logic [7:0] r;
        for (int v = 0; v < 16; v++) left[v] = 0;
        for (int i = 0; i < 4; i++) begin
            sd = s[15-4*i -: 4];
            gd = g[15-4*i -: 4];
            if (sd == gd) st[i] = 2'b11;
            else begin
                st[i] = 2'b01;
                left[sd] = left[sd] + 1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            gd = g[15-4*i -: 4];
            if (st[i] != 2'b11 && left[gd] > 0) begin
                st[i] = 2'b10;
                left[gd] = left[gd] - 1;
            end
        end
        for (int i = 0; i < 4; i++) r[7-2*i -: 2] = st[i];
        return r;
    endfunction

    // Drivers: every task starts and ends just after a falling clock edge.
    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_game(input logic [15:0] s);
        secret   = s;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        secret   = '0;
    endtask

    task automatic press_key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic press_del;
        del_btn = 1'b1;
        @(negedge clk);
        del_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic enter_guess(input logic [15:0] g);
        for (int i = 0; i < 4; i++) press_key(g[15-4*i -: 4]);
    endtask

    // Submit, count busy cycles (bounded), then wait out the result cycle.
    task automatic submit(output int bc);
        sub_btn = 1'b1;
        @(negedge clk);
        sub_btn = 1'b0;
        bc = 0;
        for (int n = 0; n < 16 && busy; n++) begin
            bc++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [34:0] got;
        do_reset;
        got = {disp_digits, disp_blank, digit_status, attempt, busy, win, lose};
        n_vec++;
        if (got !== {16'h0000, 4'hF, 8'h00, 3'd0, 3'b000}) begin
            $display("FAIL reset_values: got %h want %h", got, {16'h0000, 4'hF, 8'h00, 3'd0, 3'b000});
            n_err++;
        end
        press_key(4'd5);
        press_del;
        n_vec++;
        if ({disp_digits, disp_blank} !== {16'h0000, 4'hF}) begin
            $display("FAIL idle_ignores_keys: got %h/%b want 0000/1111", disp_digits, disp_blank);
            n_err++;
        end
    endtask

    task automatic test_scoring_directed;
        logic [15:0] s_tab [3];
        logic [15:0] g_tab [3];
        logic [7:0]  exp_st;
        int          bc;
        s_tab = '{16'h1234, 16'h1123, 16'h1203};
        g_tab = '{16'h1243, 16'h1111, 16'h3111};
        for (int t = 0; t < 3; t++) begin
            start_game(s_tab[t]);
            enter_guess(g_tab[t]);
            submit(bc);
            exp_st = ref_score(s_tab[t], g_tab[t]);
            n_vec++;
            if (digit_status !== exp_st) begin
                $display("FAIL score_dir%0d: status %b want %b", t, digit_status, exp_st);
                n_err++;
            end
            n_vec++;
            if ({attempt, win, lose} !== {3'd1, 2'b00} || bc != 5) begin
                $display("FAIL score_dir%0d_ctl: attempt %0d win %b lose %b busy %0d want 1 0 0 5",
                         t, attempt, win, lose, bc);
                n_err++;
            end
            n_vec++;
            if (disp_digits !== g_tab[t]) begin
                $display("FAIL score_dir%0d_disp: got %h want %h", t, disp_digits, g_tab[t]);
                n_err++;
            end
        end
    endtask

    task automatic test_entry_edges;
        int bc;
        start_game(16'h9876);
        n_vec++;
        if ({digit_status, attempt, disp_blank} !== {8'h00, 3'd0, 4'hF}) begin
            $display("FAIL new_game_clear: status %b attempt %0d blank %b", digit_status, attempt, disp_blank);
            n_err++;
        end
        repeat (5) press_key(4'd5);
        press_key(4'hA);
        n_vec++;
        if ({disp_digits, disp_blank} !== {16'h5555, 4'h0}) begin
            $display("FAIL entry_full: got %h/%b want 5555/0000", disp_digits, disp_blank);
            n_err++;
        end
        press_del;
        n_vec++;
        if ({disp_digits, disp_blank} !== {16'h5550, 4'b0001}) begin
            $display("FAIL delete_one: got %h/%b want 5550/0001", disp_digits, disp_blank);
            n_err++;
        end
        repeat (4) press_del;
        n_vec++;
        if ({disp_digits, disp_blank} !== {16'h0000, 4'hF}) begin
            $display("FAIL delete_all: got %h/%b want 0000/1111", disp_digits, disp_blank);
            n_err++;
        end
        press_key(4'd1);
        n_vec++;
        if ({disp_digits, disp_blank} !== {16'h1000, 4'b0111}) begin
            $display("FAIL no_underflow: got %h/%b want 1000/0111", disp_digits, disp_blank);
            n_err++;
        end
        press_key(4'd2);
        press_key(4'd3);
        submit(bc);
        n_vec++;
        if (bc != 0 || {attempt, digit_status, disp_digits, disp_blank} !== {3'd0, 8'h00, 16'h1230, 4'b0001}) begin
            $display("FAIL short_submit: busy %0d attempt %0d status %b disp %h blank %b want 0 0 0 1230 0001",
                     bc, attempt, digit_status, disp_digits, disp_blank);
            n_err++;
        end
        press_key(4'd4);
        submit(bc);
        n_vec++;
        if (digit_status !== ref_score(16'h9876, 16'h1234) || attempt !== 3'd1) begin
            $display("FAIL entry_score: status %b attempt %0d want %b 1",
                     digit_status, attempt, ref_score(16'h9876, 16'h1234));
            n_err++;
        end
    endtask

    task automatic test_simultaneous;
        start_game(16'h4321);
        press_key(4'd1);
        press_key(4'd2);
        key_valid = 1'b1; key_code = 4'd3; del_btn = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; key_code = '0; del_btn = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({disp_digits, disp_blank} !== {16'h1000, 4'b0111}) begin
            $display("FAIL key_and_delete: got %h/%b want 1000/0111", disp_digits, disp_blank);
            n_err++;
        end
        press_key(4'd2);
        press_key(4'd3);
        key_valid = 1'b1; key_code = 4'd4; sub_btn = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; key_code = '0; sub_btn = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            $display("FAIL submit_short_with_key: busy %b want 0", busy);
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if ({disp_digits, disp_blank, attempt} !== {16'h1234, 4'h0, 3'd0}) begin
            $display("FAIL key_with_submit: got %h/%b att %0d want 1234/0000 0", disp_digits, disp_blank, attempt);
            n_err++;
        end
        del_btn = 1'b1; sub_btn = 1'b1;
        @(negedge clk);
        del_btn = 1'b0; sub_btn = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            $display("FAIL submit_with_delete: busy %b want 1", busy);
            n_err++;
        end
        for (int n = 0; n < 16 && busy; n++) @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({digit_status, disp_digits, attempt} !== {ref_score(16'h4321, 16'h1234), 16'h1234, 3'd1}) begin
            $display("FAIL delete_dropped: status %b disp %h att %0d want %b 1234 1",
                     digit_status, disp_digits, attempt, ref_score(16'h4321, 16'h1234));
            n_err++;
        end
        enter_guess(16'h5678);
        sub_btn = 1'b1;
        @(negedge clk);
        sub_btn = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            $display("FAIL mid_score_busy: busy %b want 1", busy);
            n_err++;
        end
        start_game(16'h1111);
        n_vec++;
        if ({busy, attempt, digit_status, disp_digits, disp_blank} !== {1'b0, 3'd0, 8'h00, 16'h0000, 4'hF}) begin
            $display("FAIL new_game_mid_score: busy %b att %0d status %b disp %h blank %b want 0 0 0 0000 1111",
                     busy, attempt, digit_status, disp_digits, disp_blank);
            n_err++;
        end
        press_key(4'd7);
        n_vec++;
        if ({disp_digits, disp_blank} !== {16'h7000, 4'b0111}) begin
            $display("FAIL entry_after_restart: got %h/%b want 7000/0111", disp_digits, disp_blank);
            n_err++;
        end
    endtask

    task automatic test_win_lose;
        logic [15:0] s, g;
        int          bc;
        for (int i = 0; i < 4; i++) s[15-4*i -: 4] = 4'($urandom_range(0, 9));
        start_game(s);
        enter_guess(s);
        submit(bc);
        n_vec++;
        if ({win, lose, attempt, digit_status} !== {2'b10, 3'd1, ref_score(s, s)} || bc != 5) begin
            $display("FAIL win: win %b lose %b att %0d status %b busy %0d want 1 0 1 %b 5",
                     win, lose, attempt, digit_status, bc, ref_score(s, s));
            n_err++;
        end
        press_key(4'd3);
        press_del;
        n_vec++;
        if ({win, disp_digits} !== {1'b1, s}) begin
            $display("FAIL win_hold: win %b disp %h want 1 %h", win, disp_digits, s);
            n_err++;
        end
        for (int i = 0; i < 4; i++) s[15-4*i -: 4] = 4'($urandom_range(0, 9));
        start_game(s);
        for (int t = 1; t <= int'(MAX_TRIES); t++) begin
            g = s;
            while (g == s) for (int i = 0; i < 4; i++) g[15-4*i -: 4] = 4'($urandom_range(0, 9));
            enter_guess(g);
            submit(bc);
            n_vec++;
            if ({digit_status, attempt, win, lose} !== {ref_score(s, g), 3'(t), 1'b0, (t == int'(MAX_TRIES))}) begin
                $display("FAIL lose_seq%0d: status %b att %0d win %b lose %b want %b %0d 0 %b",
                         t, digit_status, attempt, win, lose, ref_score(s, g), t, (t == int'(MAX_TRIES)));
                n_err++;
            end
        end
        g = disp_digits;
        press_key(4'd2);
        submit(bc);
        n_vec++;
        if ({lose, attempt, disp_digits} !== {1'b1, 3'd6, g}) begin
            $display("FAIL lose_hold: lose %b att %0d disp %h want 1 6 %h", lose, attempt, disp_digits, g);
            n_err++;
        end
        start_game(16'h0000);
        n_vec++;
        if ({lose, attempt} !== {1'b0, 3'd0}) begin
            $display("FAIL lose_exit: lose %b att %0d want 0 0", lose, attempt);
            n_err++;
        end
    endtask

    task automatic test_random_games;
        logic [15:0] s, g;
        logic [7:0]  exp_st;
        logic        exp_win, exp_lose, all_dec;
        int          bc, att, pick;
        for (int gm = 0; gm < 10; gm++) begin
            all_dec = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    s[15-4*i -: 4] = 4'($urandom_range(10, 15));
                    all_dec = 1'b0;
                end else begin
                    s[15-4*i -: 4] = 4'($urandom_range(0, 9));
                end
            end
            start_game(s);
            att = 0; exp_win = 1'b0; exp_lose = 1'b0;
            while (!exp_win && !exp_lose) begin
                if (all_dec && $urandom_range(0, 5) == 0) g = s;
                else begin
                    for (int i = 0; i < 4; i++) begin
                        pick = $urandom_range(0, 3);
                        if ($urandom_range(0, 1) == 1 && s[15-4*pick -: 4] <= 4'd9)
                            g[15-4*i -: 4] = s[15-4*pick -: 4];
                        else
                            g[15-4*i -: 4] = 4'($urandom_range(0, 9));
                    end
                end
                enter_guess(g);
                submit(bc);
                att++;
                exp_st   = ref_score(s, g);
                exp_win  = (exp_st == 8'hFF);
                exp_lose = !exp_win && (att == int'(MAX_TRIES));
                n_vec++;
                if ({digit_status, attempt, win, lose, disp_digits} !== {exp_st, 3'(att), exp_win, exp_lose, g} || bc != 5) begin
                    $display("FAIL rand_g%0d_t%0d: s %h g %h status %b att %0d w %b l %b busy %0d want %b %0d %b %b 5",
                             gm, att, s, g, digit_status, attempt, win, lose, bc, exp_st, att, exp_win, exp_lose);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_async_reset;
        int bc;
        start_game(16'h2468);
        enter_guess(16'h8642);
        submit(bc);
        enter_guess(16'h1357);
        sub_btn = 1'b1;
        @(negedge clk);
        sub_btn = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, attempt} !== {1'b1, 3'd1}) begin
            $display("FAIL pre_reset: busy %b att %0d want 1 1", busy, attempt);
            n_err++;
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({disp_digits, disp_blank, digit_status, attempt, busy, win, lose} !==
            {16'h0000, 4'hF, 8'h00, 3'd0, 3'b000}) begin
            $display("FAIL async_reset: disp %h blank %b status %b att %0d busy %b want 0000 1111 0 0 0",
                     disp_digits, disp_blank, digit_status, attempt, busy);
            n_err++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        press_key(4'd4);
        n_vec++;
        if ({disp_digits, disp_blank} !== {16'h0000, 4'hF}) begin
            $display("FAIL idle_after_reset: got %h/%b want 0000/1111", disp_digits, disp_blank);
            n_err++;
        end
        start_game(16'h1111);
        press_key(4'd4);
        n_vec++;
        if ({disp_digits, disp_blank} !== {16'h4000, 4'b0111}) begin
            $display("FAIL entry_after_reset: got %h/%b want 4000/0111", disp_digits, disp_blank);
            n_err++;
        end
    endtask

    initial begin
        rst = 1'b1; new_game = 1'b0; secret = '0;
        key_valid = 1'b0; key_code = '0; del_btn = 1'b0; sub_btn = 1'b0;
        @(negedge clk);
        test_reset;
        test_scoring_directed;
        test_entry_edges;
        test_simultaneous;
        test_win_lose;
        test_random_games;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/numberle_guess_ctrl.md
Name: numberle_guess_ctrl

Overview:
Game sequencer for Numberle, a Wordle-style game with a 4-digit decimal code.
- Consumes decoded keypad digits and debounced btnL (delete) and btnR (submit).
- Builds the current guess, scores it against a latched secret over several cycles, and tracks attempts and win/lose.
- Sits between the keypad Decoder/Debouncing blocks and the display controller; drives display digits and per-digit status LEDs.

Parameters:
MAX_TRIES, 6, number of guesses allowed per game (1..7)
TRY_W, 3, width of attempt counter

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous active-high reset
new_game  in  1  one-cycle pulse; latch secret, start a game
secret  in  16  4 BCD digits; digit0 in [15:12]; sampled only on new_game
key_valid  in  1  one-cycle pulse: key_code is a fresh keypad press
key_code  in  4  hex key from decoder; only 0..9 accepted
del_btn  in  1  debounced delete level (btnL)
sub_btn  in  1  debounced submit level (btnR)
disp_digits  out  16  guess digits; digit0 in [15:12]
disp_blank  out  4  bit3 = digit0; 1 = digit position empty
digit_status  out  8  2 bits per digit, digit0 in [7:6]: 00 none, 01 absent, 10 misplaced, 11 correct
attempt  out  TRY_W  guesses scored this game
busy  out  1  high in SCORE_EXACT/SCORE_MISP
win  out  1  high in WIN
lose  out  1  high in LOSE

Behaviour:
Reset:
- State IDLE, all outputs 0, except disp_blank = 4'b1111.
- Guess buffer, count, used flags and secret register are all cleared.

Input conditioning:
- del_btn and sub_btn are rising-edge detected internally with one register each.
- An edge event is valid in the cycle after the level rises.

States:
IDLE:
- Waits for new_game. All other inputs are ignored.
ENTRY:
- key_valid with key_code <= 9 and count < 4: write the digit at position count, count++, clear that blank bit.
- key_code A..F: ignored.
- Key while count == 4: ignored.
- Delete edge with count > 0: count--, set that position blank, digit value -> 0.
- Delete edge with count == 0: ignored.
- Submit edge with count == 4: go to SCORE_EXACT.
- Submit edge with count < 4: ignored.
SCORE_EXACT (1 cycle):
- For each i, if guess[i] == secret[i]: status[i] = 11, mark sec_used[i] and g_done[i].
- All other status bits = 01.
- Go to SCORE_MISP with index i = 0.
SCORE_MISP (exactly 4 cycles, i = 0..3):
- If !g_done[i], find the lowest j with !sec_used[j] and secret[j] == guess[i].
- If found: status[i] = 10, set sec_used[j].
- Go to RESULT after i == 3.
RESULT (1 cycle):
- attempt++.
- All four status = 11 -> WIN.
- Else if the new attempt == MAX_TRIES -> LOSE.
- Else -> SHOW.
SHOW:
- Status and guess remain displayed.
- Next accepted digit key: clear the guess, store the key as digit0 (count = 1), reset status to 00, go to ENTRY.
- Delete and submit are ignored.
WIN / LOSE:
- Hold the display. Only new_game exits.

Latency: submit edge to valid digit_status is 6 cycles (1 exact + 4 misplaced + 1 result). busy is high for 5 cycles.

Simultaneous events:
- new_game in any state has top priority: latch secret, clear guess/status/attempt/used flags, go to ENTRY. This includes mid-score.
- key_valid and delete edge in the same cycle: delete wins, key dropped.
- Submit edge together with key or delete: submit is evaluated against count before the update; if it triggers scoring, the key/delete is dropped.
- Inputs during SCORE_* states are ignored.

Secret digits: digits > 9 are legal, compared as 4-bit values (never matched by a guess).

rst asserted mid-operation returns to IDLE immediately, with the reset values above.

Decomposition:
Package numberle_pkg:
- state enum (IDLE, ENTRY, SCORE_EXACT, SCORE_MISP, RESULT, SHOW, WIN, LOSE)
- status codes ST_NONE/ST_ABSENT/ST_MISP/ST_CORRECT
- NUM_DIGITS = 4, DIGIT_W = 4

Sub-module btn_edge: one register plus AND-NOT rising-edge detector, instantiated for del_btn and sub_btn. Scoring stays inline in the FSM.

Test Plan:
1. new_game secret=16'h1234; keys 1,2,4,3; submit -> after 6 cycles digit_status=8'b11_11_10_10, attempt=1, state SHOW.
2. Duplicates: secret 1123, guess 1111 -> status 11_11_01_01. Secret 1203, guess 3111 -> status 10_10_01_01.
3. Entry edges: key 5 ×5, key A -> count 4, digits 5555. Delete ×5 -> disp_blank=1111, no underflow. Submit with 3 digits -> no busy, attempt unchanged.
4. Win/lose: guess 1234 vs secret 1234 -> win=1 after 6 cycles. Six wrong guesses with MAX_TRIES=6 -> lose=1, attempt=6, further keys ignored.
5. Simultaneous events: key_valid and del edge in the same cycle -> only delete applied. new_game pulsed during busy -> ENTRY next cycle, attempt=0, status=0.
6. rst asserted during SCORE_MISP, asynchronously mid-cycle -> outputs at reset values immediately, IDLE; keys ignored until new_game.
